mux8_rr_arbiter: RTL
====================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-bit output channel among 8 requesters.
- Each requester presents a 4-bit word and a request bit. The block picks a winner, drives the shared 8:1 4-bit mux select, registers the selected word and offers it downstream with a valid/ready handshake.
- Sits in front of the 8:1 4-bit mux datapath as its sequencing controller.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8, sel width 3.
- DW, 4, data width per requester.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request bits; req[i] held high until ack[i].
- D0..D7  input  4 each  requester data words; must be stable while req[i] is high.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data/out_src hold a granted word.
- out_data  output  4  registered word of the current grantee.
- out_src  output  3  index of the current grantee (mux sel).
- ack  output  8  one-hot, combinational: ack[i] = out_valid & out_ready & (out_src==i).

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_src=0, ack=0, state=IDLE, last pointer=7 (first search starts at requester 0).
- States:
  - IDLE: out_valid=0.
  - BUSY: out_valid=1; out_data and out_src frozen.
- Round-robin pick: search candidates starting at (last+1) mod 8, ascending, wrapping 7->0. The first set bit wins.
- IDLE -> BUSY: at the edge where candidates (= req) is nonzero.
  - out_src <= winner; out_data <= D[winner] sampled at that edge.
  - Latency req -> out_valid: 1 cycle.
- BUSY, out_ready=0: hold everything. No ack, and no change even if req changes.
- BUSY, out_ready=1 (handshake):
  - ack[out_src]=1 in that cycle; last <= out_src.
  - Re-arbitrate in the same cycle, with candidates = req & ~onehot(out_src). This masks the stale request of the just-served source.
  - Candidates nonzero: stay BUSY with the new winner and data at the next edge. Back-to-back transfers run with zero bubbles.
  - Candidates zero: go to IDLE.
- The served source may re-request from the cycle after its ack. It then competes with lowest priority.
- A requester dropping req while not granted is ignored. A grantee dropping req while BUSY is a protocol violation: the transfer still completes.
- All 8 requesting continuously: grants rotate 0,1,...,7,0 with one grant per handshake. Maximum wait is 7 transfers.
- Reset during BUSY: the transfer is discarded, no ack is issued, and the pointer returns to 7.
- A single requester re-requesting every cycle gets one transfer per 2 cycles: an IDLE cycle between transfers, because of the masking.

Optional Feature:
- Macro MUX8_ARB_STATS_EN.
- Defined: adds output xfer_cnt (16 bits).
  - Reset to 0; increments by 1 on each handshake; wraps 0xFFFF -> 0x0000.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mux_arb_pkg holds:
  - N_REQ=8, DW=4;
  - typedef logic[3:0] nibble_t;
  - typedef logic[2:0] sel_t;
  - typedef enum logic {IDLE, BUSY} arb_state_t.
- Sub-module rr_pick8: combinational round-robin picker.
  - Inputs: cand[7:0], last sel_t.
  - Outputs: any, win sel_t.
- Data selection reuses the existing 8:1 4-bit mux, driven by the next-winner select and registered into out_data.

Test Plan:
- Reset then req=8'h01, D0=4'hA, out_ready=1 -> out_valid=1 one cycle after req, out_src=0, out_data=A, ack=8'h01 that cycle; back to IDLE next cycle.
- req=8'hFF held (re-asserted after each ack), D_i=i, out_ready=1 -> out_src sequence 0..7,0 on consecutive cycles with no gaps; out_data matches i.
- req=8'h84 after a grant to 2 -> next grant is 7, then 2.
- out_ready=0 for 5 cycles while BUSY on src 3 with D3 changing -> out_data/out_src frozen, ack=0; on out_ready=1, ack=8'h08.
- reset pulsed mid-BUSY -> next cycle out_valid=0, ack=0; a following req=8'h81 grants 0 first (pointer=7).
- With MUX8_ARB_STATS_EN: 70000 handshakes -> xfer_cnt=70000 mod 65536=4464.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 8-requester round-robin arbiter.
// Build option: MUX8_ARB_STATS_EN (consumed by mux8_rr_arbiter).
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int DW    = 4;

  typedef logic [DW-1:0] nibble_t;
  typedef logic [2:0]    sel_t;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  function automatic logic [N_REQ-1:0] onehot8(input sel_t s);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set bit of cand searching upward
// from (last+1) mod 8 with wrap-around.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  sel_t             last,
  output logic             any,
  output sel_t             win
);

  sel_t idx;

  // Walk offsets from farthest to nearest so the nearest set bit is the final assignment.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = last + sel_t'(k + 1);
      if (cand[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin sequencer for the shared 8:1 4-bit mux with a valid/ready output.
// Build option: MUX8_ARB_STATS_EN adds a 16-bit wrapping handshake counter xfer_cnt.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [DW-1:0]    D0,
  input  logic [DW-1:0]    D1,
  input  logic [DW-1:0]    D2,
  input  logic [DW-1:0]    D3,
  input  logic [DW-1:0]    D4,
  input  logic [DW-1:0]    D5,
  input  logic [DW-1:0]    D6,
  input  logic [DW-1:0]    D7,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [2:0]       out_src,
  output logic [N_REQ-1:0] ack
`ifdef MUX8_ARB_STATS_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  arb_state_t       state, state_nxt;
  sel_t             last_q;
  sel_t             pick_last;
  sel_t             win;
  logic             any;
  logic             hs;
  logic [N_REQ-1:0] cand;
  nibble_t          win_data;

  assign hs        = (state == BUSY) && out_ready;
  assign out_valid = (state == BUSY);
  assign ack       = hs ? onehot8(out_src) : '0;

  // On a handshake the served source is masked and the search starts just past it,
  // so the pointer update and re-arbitration happen in the same cycle.
  always_comb begin
    cand      = '0;
    pick_last = last_q;
    if (state == IDLE) begin
      cand = req;
    end else if (hs) begin
      cand      = req & ~onehot8(out_src);
      pick_last = out_src;
    end
  end

  rr_pick8 u_pick (
    .cand (cand),
    .last (pick_last),
    .any  (any),
    .win  (win)
  );

  always_comb begin
    win_data = D0;
    case (win)
      3'd0: win_data = D0;
      3'd1: win_data = D1;
      3'd2: win_data = D2;
      3'd3: win_data = D3;
      3'd4: win_data = D4;
      3'd5: win_data = D5;
      3'd6: win_data = D6;
      3'd7: win_data = D7;
      default: win_data = D0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any) state_nxt = BUSY;
      BUSY: if (hs)  state_nxt = any ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant register stage: winner index and its word are captured together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_q   <= 3'd7;
      out_src  <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (hs) last_q <= out_src;
      if (any) begin
        out_src  <= win;
        out_data <= win_data;
      end
    end
  end

`ifdef MUX8_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) xfer_cnt <= '0;
    else if (hs) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule
